// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants shared by the ALU datapath and its users
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_INC = 4'h3;
    localparam logic [3:0] OP_DEC = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode inputs and registered result/flag outputs of the ALU
interface alu_if #(
    parameter int B_W = 4
);
    logic [B_W-1:0] ALUA;
    logic [B_W-1:0] ALUB;
    logic [3:0]     ALUControl;
    logic           ALUFlagIn;
    logic [B_W-1:0] ALUResult;
    logic           FlagC;
    logic           FlagZ;
    logic           FlagN;
    logic           FlagV;

    // Controller side: drives operands and opcode, observes result and flags
    modport master (
        output ALUA, ALUB, ALUControl, ALUFlagIn,
        input  ALUResult, FlagC, FlagZ, FlagN, FlagV
    );

    // ALU side
    modport slave (
        input  ALUA, ALUB, ALUControl, ALUFlagIn,
        output ALUResult, FlagC, FlagZ, FlagN, FlagV
    );
endinterface

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - left/right shift by an unsigned amount with fill bit and shift-out carry
module alu_shifter #(
    parameter int B_W = 4
) (
    input  logic [B_W-1:0] i_a,
    input  logic [B_W-1:0] i_b,
    input  logic           i_fill,
    input  logic           i_left,
    output logic [B_W-1:0] o_res,
    output logic           o_c
);
    // B_W always fits in B_W bits because B_W >= 2
    localparam logic [B_W-1:0] LP_W = B_W'(B_W);

    logic [B_W-1:0] w_left;
    logic [B_W-1:0] w_right;
    logic [B_W-1:0] w_fill_lo;
    logic [B_W-1:0] w_fill_hi;
    logic [B_W:0]   w_ext_l;
    logic [B_W:0]   w_ext_r;
    logic           w_over;

    // Vector shifts already yield zero for amounts >= B_W, and the fill masks
    // become all ones, so oversized amounts need no special case for the result.
    assign w_fill_lo = ~({B_W{1'b1}} << i_b);
    assign w_fill_hi = ~({B_W{1'b1}} >> i_b);
    assign w_left    = (i_a << i_b) | (i_fill ? w_fill_lo : '0);
    assign w_right   = (i_a >> i_b) | (i_fill ? w_fill_hi : '0);

    // One extra bit catches the last bit shifted out for amounts 1..B_W;
    // amount 0 leaves it at 0. Beyond B_W the last bit out is a fill bit.
    assign w_ext_l = {1'b0, i_a} << i_b;
    assign w_ext_r = {i_a, 1'b0} >> i_b;
    assign w_over  = (i_b > LP_W);

    // Select direction and shift-out flag
    always_comb begin
        o_res = i_left ? w_left : w_right;
        if (w_over) begin
            o_c = i_fill;
        end else begin
            o_c = i_left ? w_ext_l[B_W] : w_ext_r[0];
        end
    end
endmodule

// File: rtl/alu.sv
// rtl/alu.sv - B_W-bit ALU with registered result and C/Z/N/V flags
module alu
    import alu_pkg::*;
#(
    parameter int B_W = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    logic [B_W-1:0] w_opnd;
    logic [B_W-1:0] w_add_a;
    logic [B_W-1:0] w_add_b;
    logic           w_add_cin;
    logic [B_W:0]   w_sum;
    logic           w_add_v;
    logic [B_W-1:0] w_sh_res;
    logic           w_sh_c;
    logic           w_sh_left;
    logic [B_W-1:0] w_res;
    logic           w_c;
    logic           w_v;

    logic [B_W-1:0] r_result;
    logic           r_c;
    logic           r_z;
    logic           r_n;
    logic           r_v;

    // INC/DEC/NOT pick their single operand with the flag input
    assign w_opnd    = bus.ALUFlagIn ? bus.ALUB : bus.ALUA;
    assign w_sh_left = (bus.ALUControl == OP_SHL);

    // Operand and carry-in selection for the one shared adder
    always_comb begin
        w_add_a   = bus.ALUA;
        w_add_b   = bus.ALUB;
        w_add_cin = 1'b0;
        case (bus.ALUControl)
            OP_ADD: w_add_cin = bus.ALUFlagIn;
            OP_INC: begin
                w_add_a   = w_opnd;
                w_add_b   = '0;
                w_add_cin = 1'b1;
            end
            OP_DEC: begin
                w_add_a = w_opnd;
                w_add_b = '1;
            end
            OP_SUB: begin
                w_add_b   = ~bus.ALUB;
                w_add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{B_W{1'b0}}, w_add_cin};
    // Overflow seen at the adder inputs covers ADD, INC, DEC and SUB alike
    assign w_add_v = (w_add_a[B_W-1] == w_add_b[B_W-1]) && (w_sum[B_W-1] != w_add_a[B_W-1]);

    alu_shifter #(
        .B_W (B_W)
    ) u_shifter (
        .i_a    (bus.ALUA),
        .i_b    (bus.ALUB),
        .i_fill (bus.ALUFlagIn),
        .i_left (w_sh_left),
        .o_res  (w_sh_res),
        .o_c    (w_sh_c)
    );

    // Opcode decode into next result, carry and overflow
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.ALUControl)
            OP_AND: w_res = bus.ALUA & bus.ALUB;
            OP_OR:  w_res = bus.ALUA | bus.ALUB;
            OP_ADD, OP_INC, OP_DEC, OP_SUB: begin
                w_res = w_sum[B_W-1:0];
                w_c   = w_sum[B_W];
                w_v   = w_add_v;
            end
            OP_NOT: w_res = ~w_opnd;
            OP_XOR: w_res = bus.ALUA ^ bus.ALUB;
            OP_SHL, OP_SHR: begin
                w_res = w_sh_res;
                w_c   = w_sh_c;
            end
            default: ;
        endcase
    end

    // Capture result and flags each edge; reset clears them without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_result <= w_res;
            r_c      <= w_c;
            r_z      <= (w_res == '0);
            r_n      <= w_res[B_W-1];
            r_v      <= w_v;
        end
    end

    assign bus.ALUResult = r_result;
    assign bus.FlagC     = r_c;
    assign bus.FlagZ     = r_z;
    assign bus.FlagN     = r_n;
    assign bus.FlagV     = r_v;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - vector table, reset sequences and randomized reference-model check for alu
module tb_alu;
    localparam int B_W = 4;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    alu_if #(.B_W(B_W)) bus ();

    alu #(.B_W(B_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       fin;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected {result, C, Z, N, V} from arithmetic on integers; shifts are
    // modelled one bit position at a time.
    function automatic logic [7:0] ref_model(int op, int a, int b, int fin);
        int         r;
        int         t;
        int         sa;
        int         sb;
        int         opnd;
        int         so;
        logic       c;
        logic       v;
        logic [3:0] rr;
        c    = 1'b0;
        v    = 1'b0;
        r    = 0;
        sa   = (a >= 8) ? a - 16 : a;
        sb   = (b >= 8) ? b - 16 : b;
        opnd = (fin != 0) ? b : a;
        so   = (opnd >= 8) ? opnd - 16 : opnd;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin
                t = a + b + fin;
                r = t % 16;
                c = (t >= 16);
                t = sa + sb + fin;
                v = (t > 7) || (t < -8);
            end
            3: begin
                t = opnd + 1;
                r = t % 16;
                c = (t >= 16);
                v = (so + 1 > 7);
            end
            4: begin
                r = (opnd + 15) % 16;
                c = (opnd != 0);
                v = (so - 1 < -8);
            end
            5: r = 15 - opnd;
            6: begin
                r = (a - b + 16) % 16;
                c = (a >= b);
                t = sa - sb;
                v = (t > 7) || (t < -8);
            end
            7: r = a ^ b;
            8: begin
                r = a;
                for (int k = 0; k < b; k++) begin
                    c = ((r >> 3) & 1) != 0;
                    r = ((r << 1) | fin) & 15;
                end
            end
            9: begin
                r = a;
                for (int k = 0; k < b; k++) begin
                    c = (r & 1) != 0;
                    r = (r >> 1) | (fin << 3);
                end
            end
            default: r = 0;
        endcase
        rr = r[3:0];
        return {rr, c, (rr == 4'd0), rr[3], v};
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.ALUResult, bus.FlagC, bus.FlagZ, bus.FlagN, bus.FlagV};
    endfunction

    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got res=%b CZNV=%b, need res=%b CZNV=%b",
                     name, got[7:4], got[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    // Drive between edges, let one rising edge capture, sample just after it
    task automatic apply(logic [3:0] op, logic [3:0] a, logic [3:0] b, logic fin);
        @(negedge clk);
        bus.ALUControl = op;
        bus.ALUA       = a;
        bus.ALUB       = b;
        bus.ALUFlagIn  = fin;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(string name, logic [3:0] op, logic [3:0] a, logic [3:0] b,
                           logic fin, logic [3:0] res, logic c, logic z, logic n, logic v);
        vec_t e;
        e.name = name;
        e.op   = op;
        e.a    = a;
        e.b    = b;
        e.fin  = fin;
        e.exp  = {res, c, z, n, v};
        vecs.push_back(e);
    endtask

    initial begin
        n_total        = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        bus.ALUControl = 4'h2;
        bus.ALUA       = 4'hF;
        bus.ALUB       = 4'hF;
        bus.ALUFlagIn  = 1'b1;

        //         name          op    a      b      fin   res    C Z N V
        add_vec("add_carry",    4'h2, 4'hF, 4'h7, 1'b0, 4'h6, 1, 0, 0, 0);
        add_vec("add_ovf",      4'h2, 4'h7, 4'h1, 1'b0, 4'h8, 0, 0, 1, 1);
        add_vec("add_cin",      4'h2, 4'hF, 4'h0, 1'b1, 4'h0, 1, 1, 0, 0);
        add_vec("sub_eq",       4'h6, 4'h3, 4'h3, 1'b0, 4'h0, 1, 1, 0, 0);
        add_vec("sub_borrow",   4'h6, 4'h2, 4'h3, 1'b0, 4'hF, 0, 0, 1, 0);
        add_vec("shl_fill",     4'h8, 4'h3, 4'h2, 1'b1, 4'hF, 0, 0, 1, 0);
        add_vec("shr_one",      4'h9, 4'h9, 4'h1, 1'b0, 4'h4, 1, 0, 0, 0);
        add_vec("reserved_c",   4'hC, 4'hF, 4'hF, 1'b1, 4'h0, 0, 1, 0, 0);
        add_vec("dec_zero",     4'h4, 4'h0, 4'h5, 1'b0, 4'hF, 0, 0, 1, 0);
        add_vec("dec_minneg",   4'h4, 4'h8, 4'h5, 1'b0, 4'h7, 1, 0, 0, 1);
        add_vec("inc_b_ovf",    4'h3, 4'h0, 4'h7, 1'b1, 4'h8, 0, 0, 1, 1);
        add_vec("shl_by_w",     4'h8, 4'h5, 4'h4, 1'b0, 4'h0, 1, 1, 0, 0);
        add_vec("shl_past_w",   4'h8, 4'h0, 4'h5, 1'b1, 4'hF, 1, 0, 1, 0);
        add_vec("shr_by_w",     4'h9, 4'h8, 4'h4, 1'b0, 4'h0, 1, 1, 0, 0);
        add_vec("shl_zero",     4'h8, 4'hA, 4'h0, 1'b1, 4'hA, 0, 0, 1, 0);
        add_vec("not_b",        4'h5, 4'h0, 4'h3, 1'b1, 4'hC, 0, 0, 1, 0);
        add_vec("and",          4'h0, 4'hC, 4'hA, 1'b0, 4'h8, 0, 0, 1, 0);
        add_vec("or_zero",      4'h1, 4'h0, 4'h0, 1'b1, 4'h0, 0, 1, 0, 0);
        add_vec("xor_same",     4'h7, 4'hA, 4'hA, 1'b0, 4'h0, 0, 1, 0, 0);

        // Outputs stay cleared while reset is held across edges
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", dut_out(), 8'h00);

        // First capture on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", dut_out(), ref_model(2, 15, 15, 1));

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fin);
            check(vecs[i].name, dut_out(), vecs[i].exp);
        end

        // Asynchronous reset between edges clears outputs with no clock edge
        apply(4'h2, 4'h7, 4'h1, 1'b0);
        check("pre_reset", dut_out(), 8'h81 | 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_out(), 8'h00);
        @(posedge clk);
        #1;
        check("reset_discard", dut_out(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back operations, one per cycle
        apply(4'h6, 4'h3, 4'h3, 1'b0);
        check("b2b_sub0", dut_out(), 8'h0C);
        apply(4'h6, 4'h2, 4'h3, 1'b0);
        check("b2b_sub1", dut_out(), 8'hF2);

        // Randomized sweep against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            logic [3:0] a;
            logic [3:0] b;
            logic       fin;
            op  = 4'($urandom_range(0, 15));
            a   = 4'($urandom);
            b   = 4'($urandom);
            fin = 1'($urandom);
            apply(op, a, b, fin);
            check($sformatf("rand%0d_op%0h_a%0h_b%0h_f%0d", i, op, a, b, fin),
                  dut_out(), ref_model(int'(op), int'(a), int'(b), int'(fin)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
